// File: rtl/ysyx_22040228_div_issue_pkg.sv
// Shared definitions for the divide-issue slice: opcode codes, issue FSM encodings,
// the watchdog default and opcode classification.
package ysyx_22040228_div_issue_pkg;

    localparam logic [7:0] INST_DIV   = 8'h40;
    localparam logic [7:0] INST_DIVU  = 8'h41;
    localparam logic [7:0] INST_DIVW  = 8'h42;
    localparam logic [7:0] INST_DIVUW = 8'h43;
    localparam logic [7:0] INST_REM   = 8'h44;
    localparam logic [7:0] INST_REMU  = 8'h45;
    localparam logic [7:0] INST_REMW  = 8'h46;
    localparam logic [7:0] INST_REMUW = 8'h47;

    localparam logic [2:0] ysyx22040228_DIVQ_IDLE  = 3'd0;
    localparam logic [2:0] ysyx22040228_DIVQ_FAST  = 3'd1;
    localparam logic [2:0] ysyx22040228_DIVQ_ISSUE = 3'd2;
    localparam logic [2:0] ysyx22040228_DIVQ_WAIT  = 3'd3;
    localparam logic [2:0] ysyx22040228_DIVQ_DONE  = 3'd4;
    localparam logic [2:0] ysyx22040228_DIVQ_DRAIN = 3'd5;

    localparam int ysyx22040228_DIVQ_TIMEOUT = 80;

    typedef struct packed {
        logic is_div;
        logic is_word;
        logic is_signed;
        logic is_rem;
    } div_kind_t;

    function automatic div_kind_t decode_div(input logic [7:0] op);
        div_kind_t k;
        k.is_div    = op inside {INST_DIV, INST_DIVU, INST_DIVW, INST_DIVUW,
                                 INST_REM, INST_REMU, INST_REMW, INST_REMUW};
        k.is_word   = op inside {INST_DIVW, INST_DIVUW, INST_REMW, INST_REMUW};
        k.is_signed = op inside {INST_DIV, INST_DIVW, INST_REM, INST_REMW};
        k.is_rem    = op inside {INST_REM, INST_REMU, INST_REMW, INST_REMUW};
        return k;
    endfunction

endpackage

// File: rtl/ysyx_22040228_div_issue_special.sv
// Combinational operand preparation (W-op extension) and detection of the divide
// cases that are answered without the iterative divider.
module ysyx_22040228div_special
    import ysyx_22040228_div_issue_pkg::*;
(
    input  logic [7:0]  opcode,
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    output logic        div_class,
    output logic        is_word,
    output logic [63:0] dividend,
    output logic [63:0] divisor,
    output logic        special,
    output logic [63:0] special_result
);

    div_kind_t kind;
    logic      div_zero;
    logic      overflow;

    always_comb begin
        kind      = decode_div(opcode);
        div_class = kind.is_div;
        is_word   = kind.is_word;

        if (kind.is_word && kind.is_signed) begin
            dividend = {{32{src1[31]}}, src1[31:0]};
            divisor  = {{32{src2[31]}}, src2[31:0]};
        end else if (kind.is_word) begin
            dividend = {32'd0, src1[31:0]};
            divisor  = {32'd0, src2[31:0]};
        end else begin
            dividend = src1;
            divisor  = src2;
        end

        // Overflow is only the most-negative / -1 pair at the operation's own width.
        div_zero = (divisor == 64'd0);
        if (kind.is_word)
            overflow = kind.is_signed && (src1[31:0] == 32'h8000_0000) && (src2[31:0] == 32'hFFFF_FFFF);
        else
            overflow = kind.is_signed && (src1 == 64'h8000_0000_0000_0000) && (src2 == '1);

        special = div_zero | overflow;
        if (div_zero)
            special_result = kind.is_rem ? dividend : '1;
        else if (overflow)
            special_result = kind.is_rem ? 64'd0 : dividend;
        else
            special_result = 64'd0;
    end

endmodule

// File: rtl/ysyx_22040228_div_issue.sv
// Issue/collect controller between the EX stage and a multi-cycle divider, with a
// fast path for trivial cases, flush draining and a sticky watchdog.
module ysyx_22040228_div_issue
    import ysyx_22040228_div_issue_pkg::*;
#(
    parameter int TIMEOUT = ysyx22040228_DIVQ_TIMEOUT
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [7:0]  ex_opcode,
    input  logic [63:0] ex_src1,
    input  logic [63:0] ex_src2,
    input  logic        ex_flush,
    output logic        ex_stall,
    output logic [63:0] ex_result,
    output logic        ex_result_valid,
    output logic        div_ready,
    output logic [63:0] div_dividend,
    output logic [63:0] div_diviser,
    output logic [7:0]  div_opcode,
    input  logic [63:0] div_rem_data,
    input  logic        div_finish,
    output logic        err_timeout
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [2:0]      state;
    logic [WD_W-1:0] wd_cnt;
    logic [63:0]     dividend_q;
    logic [63:0]     diviser_q;
    logic [7:0]      opcode_q;
    logic [63:0]     result_q;
    logic            word_q;
    logic            err_q;

    logic            div_class;
    logic            is_word;
    logic [63:0]     prep_dividend;
    logic [63:0]     prep_divisor;
    logic            special;
    logic [63:0]     special_result;
    logic            accept;
    logic            wd_expired;
    logic [63:0]     finish_data;

    ysyx_22040228div_special u_special (
        .opcode         (ex_opcode),
        .src1           (ex_src1),
        .src2           (ex_src2),
        .div_class      (div_class),
        .is_word        (is_word),
        .dividend       (prep_dividend),
        .divisor        (prep_divisor),
        .special        (special),
        .special_result (special_result)
    );

    assign accept      = (state == ysyx22040228_DIVQ_IDLE) & ex_valid & div_class & ~ex_flush;
    assign wd_expired  = (wd_cnt == WD_W'(TIMEOUT - 1));
    assign finish_data = word_q ? {{32{div_rem_data[31]}}, div_rem_data[31:0]} : div_rem_data;

    // The divider operands stay in their registers until the next accept, so they
    // remain stable for the whole divider run and the cycle after its finish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ysyx22040228_DIVQ_IDLE;
            wd_cnt     <= '0;
            dividend_q <= 64'd0;
            diviser_q  <= 64'd0;
            opcode_q   <= 8'd0;
            result_q   <= 64'd0;
            word_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                ysyx22040228_DIVQ_IDLE: begin
                    if (accept) begin
                        opcode_q   <= ex_opcode;
                        dividend_q <= prep_dividend;
                        diviser_q  <= prep_divisor;
                        word_q     <= is_word;
                        wd_cnt     <= '0;
                        if (special) begin
                            result_q <= special_result;
                            state    <= ysyx22040228_DIVQ_FAST;
                        end else begin
                            state    <= ysyx22040228_DIVQ_ISSUE;
                        end
                    end
                end
                ysyx22040228_DIVQ_FAST:
                    state <= ex_flush ? ysyx22040228_DIVQ_IDLE : ysyx22040228_DIVQ_DONE;
                ysyx22040228_DIVQ_ISSUE:
                    state <= ex_flush ? ysyx22040228_DIVQ_DRAIN : ysyx22040228_DIVQ_WAIT;
                ysyx22040228_DIVQ_WAIT: begin
                    if (div_finish) begin
                        wd_cnt <= '0;
                        if (ex_flush) begin
                            state <= ysyx22040228_DIVQ_IDLE;
                        end else begin
                            result_q <= finish_data;
                            state    <= ysyx22040228_DIVQ_DONE;
                        end
                    end else if (wd_expired) begin
                        err_q    <= 1'b1;
                        wd_cnt   <= '0;
                        result_q <= 64'd0;
                        state    <= ex_flush ? ysyx22040228_DIVQ_IDLE : ysyx22040228_DIVQ_DONE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (ex_flush)
                            state <= ysyx22040228_DIVQ_DRAIN;
                    end
                end
                ysyx22040228_DIVQ_DRAIN: begin
                    if (div_finish || wd_expired) begin
                        wd_cnt <= '0;
                        state  <= ysyx22040228_DIVQ_IDLE;
                        if (!div_finish)
                            err_q <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                ysyx22040228_DIVQ_DONE:
                    state <= ysyx22040228_DIVQ_IDLE;
                default:
                    state <= ysyx22040228_DIVQ_IDLE;
            endcase
        end
    end

    assign ex_stall        = ex_valid & div_class & (state != ysyx22040228_DIVQ_DONE);
    assign ex_result_valid = (state == ysyx22040228_DIVQ_DONE) & ~ex_flush;
    assign ex_result       = result_q;
    assign div_ready       = (state == ysyx22040228_DIVQ_ISSUE);
    assign div_dividend    = dividend_q;
    assign div_diviser     = diviser_q;
    assign div_opcode      = opcode_q;
    assign err_timeout     = err_q;

endmodule

// File: tb/tb_ysyx_22040228_div_issue.sv
// Self-checking bench for the divide-issue controller: a table of divide cases fed
// through a behavioural divider, plus flush, watchdog and reset sequences.
module tb_ysyx_22040228_div_issue;
    import ysyx_22040228_div_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [7:0]  ex_opcode;
    logic [63:0] ex_src1;
    logic [63:0] ex_src2;
    logic        ex_flush;
    logic        ex_stall;
    logic [63:0] ex_result;
    logic        ex_result_valid;
    logic        div_ready;
    logic [63:0] div_dividend;
    logic [63:0] div_diviser;
    logic [7:0]  div_opcode;
    logic [63:0] div_rem_data;
    logic        div_finish;
    logic        err_timeout;

    ysyx_22040228_div_issue dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_flush(ex_flush), .ex_stall(ex_stall),
        .ex_result(ex_result), .ex_result_valid(ex_result_valid), .div_ready(div_ready),
        .div_dividend(div_dividend), .div_diviser(div_diviser), .div_opcode(div_opcode),
        .div_rem_data(div_rem_data), .div_finish(div_finish), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        bit          fast;
    } vec_t;

    vec_t        vecs[12];
    logic [63:0] sb[$];
    int checks = 0, errors = 0, cyc = 0;
    int rdy_count = 0, rv_count = 0;
    int last_rdy_cyc = 0, last_fin_cyc = 0, last_rv_cyc = 0;
    logic [63:0] held_dvd;
    bit   hold_en = 0;
    int   div_latency = 4;
    bit   div_hang = 0, spurious_req = 0, pending = 0;
    int   cnt = 0;
    logic [63:0] raw = 64'd0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Raw divider result: W ops return only the low 32 bits with a zero upper half.
    function automatic logic [63:0] model_divider(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] sa, sbv;
        logic signed [31:0] wa, wb;
        logic [31:0] r32;
        sa = a; sbv = b; wa = a[31:0]; wb = b[31:0];
        if (b == 64'd0) return 64'd0;
        case (op)
            INST_DIV:   return 64'(sa / sbv);
            INST_DIVU:  return a / b;
            INST_REM:   return 64'(sa % sbv);
            INST_REMU:  return a % b;
            INST_DIVW:  r32 = 32'(wa / wb);
            INST_DIVUW: r32 = a[31:0] / b[31:0];
            INST_REMW:  r32 = 32'(wa % wb);
            default:    r32 = a[31:0] % b[31:0];
        endcase
        return {32'd0, r32};
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural divider, driven just after each rising edge.
    initial begin
        div_finish   = 1'b0;
        div_rem_data = 64'd0;
        forever begin
            @(posedge clk);
            #1;
            div_finish = 1'b0;
            if (spurious_req) begin
                div_finish   = 1'b1;
                div_rem_data = 64'hDEAD_BEEF_0BAD_F00D;
                spurious_req = 0;
            end else if (pending) begin
                if (cnt <= 1) begin
                    div_finish   = 1'b1;
                    div_rem_data = raw;
                    pending      = 0;
                end else begin
                    cnt--;
                end
            end
            if (div_ready && !rst && !div_hang) begin
                pending = 1;
                cnt     = div_latency;
                raw     = model_divider(div_opcode, div_dividend, div_diviser);
            end
        end
    end

    // Scoreboard monitor on the falling edge.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (div_ready) begin
                rdy_count++;
                last_rdy_cyc = cyc;
                held_dvd     = div_dividend;
                hold_en      = 1;
            end
            if (div_finish) begin
                last_fin_cyc = cyc;
                if (hold_en) checkOutput("hold_dividend", div_dividend, held_dvd);
                hold_en = 0;
            end
            if (ex_result_valid) begin
                rv_count++;
                last_rv_cyc = cyc;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_result actual=%h expected=none", ex_result);
                end else begin
                    checkOutput("result", ex_result, sb.pop_front());
                end
            end
        end
    end

    task automatic waitUnstall(input int limit);
        int n;
        for (n = 0; n < limit; n++) begin
            @(negedge clk);
            if (!ex_stall) break;
        end
        if (n == limit) checkOutput("stall_timeout", 64'(n), 64'(0));
        #1;
        ex_valid = 1'b0;
    endtask

    task automatic waitReady(input int limit);
        int n;
        for (n = 0; n < limit; n++) begin
            @(negedge clk);
            if (div_ready) break;
        end
        if (n == limit) checkOutput("ready_timeout", 64'(n), 64'(0));
    endtask

    task automatic applyStimulus(input logic [7:0] op, input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] exp, output int c0);
        @(negedge clk);
        ex_opcode = op; ex_src1 = a; ex_src2 = b; ex_valid = 1'b1;
        sb.push_back(exp);
        c0 = cyc;
        waitUnstall(200);
    endtask

    initial begin
        int c0, r_rdy, r_rv, fin1, n;
        logic [63:0] last_res;
        vecs[0]  = '{INST_DIVU,  64'd100, 64'd7, 64'd14, 1'b0};
        vecs[1]  = '{INST_REM,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[2]  = '{INST_DIV,   64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[3]  = '{INST_REMU,  64'd5, 64'd0, 64'd5, 1'b1};
        vecs[4]  = '{INST_DIVW,  64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1'b1};
        vecs[5]  = '{INST_DIV,   64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0};
        vecs[6]  = '{INST_REMW,  64'h0000_0000_FFFF_FFF1, 64'd4, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0};
        vecs[7]  = '{INST_DIVUW, 64'h1234_5678_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[8]  = '{INST_DIV,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1};
        vecs[9]  = '{INST_REM,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1};
        vecs[10] = '{INST_REMUW, 64'h0000_0001_0000_0007, 64'h0000_0001_0000_0004, 64'd3, 1'b0};
        vecs[11] = '{INST_DIVU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 64'h0FFF_FFFF_FFFF_FFFF, 1'b0};

        rst = 1'b1; ex_valid = 1'b0; ex_opcode = 8'd0; ex_src1 = 64'd0; ex_src2 = 64'd0; ex_flush = 1'b0;
        #12;
        checkOutput("reset_result_valid", 64'(ex_result_valid), 64'(0));
        checkOutput("reset_div_ready", 64'(div_ready), 64'(0));
        checkOutput("reset_err_timeout", 64'(err_timeout), 64'(0));
        checkOutput("reset_result", ex_result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            div_latency = 3 + (i % 4);
            r_rdy = rdy_count;
            r_rv  = rv_count;
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, c0);
            checkOutput($sformatf("v%0d_valid_pulses", i), 64'(rv_count - r_rv), 64'(1));
            checkOutput($sformatf("v%0d_ready_pulses", i), 64'(rdy_count - r_rdy), vecs[i].fast ? 64'(0) : 64'(1));
            if (vecs[i].fast) begin
                checkOutput($sformatf("v%0d_fast_latency", i), 64'(last_rv_cyc - c0), 64'(2));
            end else begin
                checkOutput($sformatf("v%0d_ready_latency", i), 64'(last_rdy_cyc - c0), 64'(1));
                checkOutput($sformatf("v%0d_finish_to_valid", i), 64'(last_rv_cyc - last_fin_cyc), 64'(1));
            end
        end

        // A divider finish while idle must not produce a result.
        last_res = ex_result;
        r_rv = rv_count;
        @(negedge clk);
        spurious_req = 1;
        repeat (4) @(negedge clk);
        checkOutput("spurious_valid", 64'(rv_count - r_rv), 64'(0));
        checkOutput("spurious_result", ex_result, last_res);

        // Flush in WAIT drains the divider, then the next op issues.
        $display("[TB] flush sequence");
        div_latency = 30;
        r_rdy = rdy_count;
        r_rv  = rv_count;
        @(negedge clk);
        ex_opcode = INST_DIVU; ex_src1 = 64'd40; ex_src2 = 64'd4; ex_valid = 1'b1;
        waitReady(20);
        repeat (10) @(negedge clk);
        ex_flush = 1'b1; ex_valid = 1'b0;
        @(negedge clk);
        ex_flush = 1'b0;
        div_latency = 4;
        ex_opcode = INST_DIVU; ex_src1 = 64'd9; ex_src2 = 64'd3; ex_valid = 1'b1;
        sb.push_back(64'd3);
        fin1 = -1;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (div_finish && fin1 < 0) fin1 = cyc;
            if (!ex_stall) break;
        end
        if (n == 100) checkOutput("flush_stall_timeout", 64'(n), 64'(0));
        #1;
        ex_valid = 1'b0;
        checkOutput("flush_valid_pulses", 64'(rv_count - r_rv), 64'(1));
        checkOutput("flush_ready_pulses", 64'(rdy_count - r_rdy), 64'(2));
        checkOutput("flush_issue_spacing", 64'(last_rdy_cyc - fin1 >= 2), 64'(1));
        checkOutput("flush_new_dividend", div_dividend, 64'd9);

        // Watchdog: the divider never finishes.
        $display("[TB] watchdog sequence");
        div_hang = 1;
        r_rv = rv_count;
        @(negedge clk);
        ex_opcode = INST_DIVU; ex_src1 = 64'd7; ex_src2 = 64'd7; ex_valid = 1'b1;
        sb.push_back(64'd0);
        waitReady(20);
        c0 = cyc;
        repeat (40) @(negedge clk);
        checkOutput("err_timeout_early", 64'(err_timeout), 64'(0));
        waitUnstall(100);
        checkOutput("err_timeout_set", 64'(err_timeout), 64'(1));
        checkOutput("timeout_valid_pulses", 64'(rv_count - r_rv), 64'(1));
        checkOutput("timeout_window", 64'((last_rv_cyc - c0 >= 80) && (last_rv_cyc - c0 <= 82)), 64'(1));
        repeat (5) @(negedge clk);
        checkOutput("err_timeout_sticky", 64'(err_timeout), 64'(1));
        div_hang = 0;
        hold_en  = 0;

        // Asynchronous reset in the middle of a divide.
        $display("[TB] reset sequence");
        div_latency = 20;
        @(negedge clk);
        ex_opcode = INST_DIV; ex_src1 = 64'd50; ex_src2 = 64'd5; ex_valid = 1'b1;
        waitReady(20);
        repeat (3) @(negedge clk);
        ex_valid = 1'b0;
        rst = 1'b1;
        hold_en = 0;
        #1;
        checkOutput("rst_div_ready", 64'(div_ready), 64'(0));
        checkOutput("rst_result_valid", 64'(ex_result_valid), 64'(0));
        checkOutput("rst_result", ex_result, 64'd0);
        checkOutput("rst_dividend", div_dividend, 64'd0);
        checkOutput("rst_diviser", div_diviser, 64'd0);
        checkOutput("rst_opcode", 64'(div_opcode), 64'(0));
        checkOutput("rst_err_timeout", 64'(err_timeout), 64'(0));
        checkOutput("rst_stall", 64'(ex_stall), 64'(0));
        r_rv = rv_count;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        checkOutput("rst_no_result", 64'(rv_count - r_rv), 64'(0));
        checkOutput("rst_result_held", ex_result, 64'd0);
        checkOutput("scoreboard_empty", 64'(sb.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
